// File: rtl/mor1kx_dpram_ctrl_sclk.sv
// Front-end for a simple dual-port RAM: two write requesters arbitrated round-robin, one read port,
// and a zero-fill sweep after reset or flush during which every request is refused.
module mor1kx_dpram_ctrl_sclk #(
  parameter int ADDR_WIDTH     = 5,
  parameter int DATA_WIDTH     = 32,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  output logic                  busy_o,
  input  logic                  wr_req_a_i,
  input  logic                  wr_req_b_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_a_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_b_i,
  input  logic [DATA_WIDTH-1:0] wr_data_a_i,
  input  logic [DATA_WIDTH-1:0] wr_data_b_i,
  output logic                  wr_ack_a_o,
  output logic                  wr_ack_b_o,
  input  logic                  rd_req_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic                  rd_ack_o,
  output logic                  rd_valid_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic [ADDR_WIDTH-1:0] ram_raddr_o,
  output logic                  ram_re_o,
  output logic [ADDR_WIDTH-1:0] ram_waddr_o,
  output logic                  ram_we_o,
  output logic [DATA_WIDTH-1:0] ram_din_o,
  input  logic [DATA_WIDTH-1:0] ram_dout_i
);

  typedef enum logic {CLEAR, RUN} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;
  logic                  ptr, ptr_nxt;   // 0 = A wins the next contested cycle
  logic                  rd_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= CLEAR_ON_RESET ? CLEAR : RUN;
      cnt      <= '0;
      ptr      <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      ptr      <= ptr_nxt;
      rd_valid <= rd_ack_o;
    end
  end

  assign rd_valid_o = rd_valid;
  assign rd_data_o  = ram_dout_i;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    ptr_nxt     = ptr;
    busy_o      = 1'b0;
    wr_ack_a_o  = 1'b0;
    wr_ack_b_o  = 1'b0;
    rd_ack_o    = 1'b0;
    ram_re_o    = 1'b0;
    ram_raddr_o = rd_addr_i;
    ram_we_o    = 1'b0;
    ram_waddr_o = cnt;
    ram_din_o   = '0;
    // Everything is held quiet while reset is asserted, whatever the registered state.
    if (rst_n) begin
      case (state)
        CLEAR: begin
          busy_o   = 1'b1;
          ram_we_o = 1'b1;
          cnt_nxt  = cnt + ADDR_WIDTH'(1);
          if (cnt == LAST_ADDR) state_nxt = RUN;
        end
        default: begin
          wr_ack_a_o = wr_req_a_i && (!wr_req_b_i || !ptr);
          wr_ack_b_o = wr_req_b_i && (!wr_req_a_i || ptr);
          if (wr_req_a_i && wr_req_b_i) ptr_nxt = ~ptr;
          ram_we_o    = wr_ack_a_o || wr_ack_b_o;
          ram_waddr_o = wr_ack_b_o ? wr_addr_b_i : wr_addr_a_i;
          ram_din_o   = wr_ack_b_o ? wr_data_b_i : wr_data_a_i;
          rd_ack_o    = rd_req_i;
          ram_re_o    = rd_req_i;
        end
      endcase
      if (flush_i) begin
        state_nxt = CLEAR;
        cnt_nxt   = '0;
      end
    end
  end

endmodule

// File: tb/tb_mor1kx_dpram_ctrl_sclk.sv
// Directed bench for mor1kx_dpram_ctrl_sclk (ADDR_WIDTH=3) with a behavioural bypassing RAM.
module tb_mor1kx_dpram_ctrl_sclk;

  logic        clk = 1'b0;
  logic        rst_n, flush, busy;
  logic        wr_req_a, wr_req_b, ack_a, ack_b;
  logic [2:0]  wr_addr_a, wr_addr_b, rd_addr, ram_raddr, ram_waddr;
  logic [31:0] wr_data_a, wr_data_b, rd_data, ram_din, ram_dout;
  logic        rd_req, rd_ack, rd_valid, ram_re, ram_we;
  logic [31:0] mem [8];
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  mor1kx_dpram_ctrl_sclk #(.ADDR_WIDTH(3), .DATA_WIDTH(32), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .busy_o(busy),
    .wr_req_a_i(wr_req_a), .wr_req_b_i(wr_req_b),
    .wr_addr_a_i(wr_addr_a), .wr_addr_b_i(wr_addr_b),
    .wr_data_a_i(wr_data_a), .wr_data_b_i(wr_data_b),
    .wr_ack_a_o(ack_a), .wr_ack_b_o(ack_b),
    .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_ack_o(rd_ack),
    .rd_valid_o(rd_valid), .rd_data_o(rd_data),
    .ram_raddr_o(ram_raddr), .ram_re_o(ram_re), .ram_waddr_o(ram_waddr),
    .ram_we_o(ram_we), .ram_din_o(ram_din), .ram_dout_i(ram_dout)
  );

  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_din;
    if (ram_re) ram_dout <= (ram_we && ram_waddr == ram_raddr) ? ram_din : mem[ram_raddr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 1'b0; wr_req_a = 1'b0; wr_req_b = 1'b0; rd_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_req_a = 1'b1; wr_req_b = 1'b1; rd_req = 1'b1;
    repeat (2) tick();
    vectors++;
    if ({busy, ack_a, ack_b, ram_we, ram_re, rd_ack, rd_valid} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got busy/acka/ackb/we/re/rdack/rdvalid=%b required 0000000",
               {busy, ack_a, ack_b, ram_we, ram_re, rd_ack, rd_valid});
    end
    idle_inputs();
  endtask

  // Expects the block to be at sweep counter 0 in CLEAR; requests stay asserted to prove refusal.
  task automatic check_sweep(input string name);
    wr_req_a = 1'b1; rd_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      vectors++;
      if (busy !== 1'b1 || ram_we !== 1'b1 || ram_waddr !== 3'(i) || ram_din !== 32'h0 ||
          ack_a !== 1'b0 || rd_ack !== 1'b0 || ram_re !== 1'b0) begin
        miscompares++;
        $display("FAIL %s_cycle%0d: got busy=%b we=%b waddr=%0d din=%h acka=%b rdack=%b re=%b required 1 1 %0d 0 0 0 0",
                 name, i, busy, ram_we, ram_waddr, ram_din, ack_a, rd_ack, ram_re, i);
      end
      tick();
    end
    idle_inputs();
    #1;
    vectors++;
    if (busy !== 1'b0 || ram_we !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_end: got busy=%b we=%b required 0 0", name, busy, ram_we);
    end
  endtask

  task automatic do_read(input string name, input logic [2:0] addr, input logic [31:0] exp);
    rd_req = 1'b1; rd_addr = addr;
    #1;
    vectors++;
    if (rd_ack !== 1'b1 || ram_re !== 1'b1 || ram_raddr !== addr) begin
      miscompares++;
      $display("FAIL %s_issue: got rdack=%b re=%b raddr=%0d required 1 1 %0d", name, rd_ack, ram_re, ram_raddr, addr);
    end
    tick();
    rd_req = 1'b0;
    vectors++;
    if (rd_valid !== 1'b1 || rd_data !== exp) begin
      miscompares++;
      $display("FAIL %s_data: got valid=%b data=%h required 1 %h", name, rd_valid, rd_data, exp);
    end
  endtask

  task automatic test_sweep_after_reset();
    rst_n = 1'b1;
    check_sweep("sweep");
    do_read("read5", 3'd5, 32'h0);
    tick();
    vectors++;
    if (rd_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rd_valid_drop: got %b required 0", rd_valid);
    end
  endtask

  task automatic test_single_write();
    wr_req_a = 1'b1; wr_addr_a = 3'd2; wr_data_a = 32'hDEADBEEF;
    #1;
    vectors++;
    if (ack_a !== 1'b1 || ack_b !== 1'b0 || ram_we !== 1'b1 || ram_waddr !== 3'd2 || ram_din !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL write_a: got acka=%b ackb=%b we=%b waddr=%0d din=%h required 1 0 1 2 deadbeef",
               ack_a, ack_b, ram_we, ram_waddr, ram_din);
    end
    tick();
    wr_req_a = 1'b0;
    do_read("read2", 3'd2, 32'hDEADBEEF);
    wr_req_b = 1'b1; wr_addr_b = 3'd6; wr_data_b = 32'hCAFE0006;
    #1;
    vectors++;
    if (ack_b !== 1'b1 || ack_a !== 1'b0 || ram_waddr !== 3'd6 || ram_din !== 32'hCAFE0006) begin
      miscompares++;
      $display("FAIL write_b: got ackb=%b acka=%b waddr=%0d din=%h required 1 0 6 cafe0006",
               ack_b, ack_a, ram_waddr, ram_din);
    end
    tick();
    wr_req_b = 1'b0;
  endtask

  // Pointer is at A here: single-request cycles so far must not have moved it.
  task automatic test_arbitration();
    logic [6:0] req_a = 7'b1111111;
    logic [6:0] req_b = 7'b1011111;
    logic [6:0] exp_a = 7'b0110101;
    wr_addr_a = 3'd1; wr_data_a = 32'h11111111;
    wr_addr_b = 3'd4; wr_data_b = 32'h44444444;
    for (int i = 0; i < 7; i++) begin
      wr_req_a = req_a[i]; wr_req_b = req_b[i];
      #1;
      vectors++;
      if (ack_a !== exp_a[i] || ack_b !== !exp_a[i] ||
          ram_waddr !== (exp_a[i] ? 3'd1 : 3'd4) || ram_din !== (exp_a[i] ? 32'h11111111 : 32'h44444444)) begin
        miscompares++;
        $display("FAIL arb_cycle%0d: got acka=%b ackb=%b waddr=%0d din=%h required acka=%b ackb=%b",
                 i, ack_a, ack_b, ram_waddr, ram_din, exp_a[i], !exp_a[i]);
      end
      tick();
    end
    idle_inputs();
    do_read("read_arb_b", 3'd4, 32'h44444444);
  endtask

  task automatic test_back_to_back_bypass();
    wr_req_a = 1'b1; wr_addr_a = 3'd3; wr_data_a = 32'h12345678;
    rd_req = 1'b1; rd_addr = 3'd3;
    #1;
    vectors++;
    if (ack_a !== 1'b1 || rd_ack !== 1'b1 || ram_we !== 1'b1 || ram_re !== 1'b1) begin
      miscompares++;
      $display("FAIL bypass_issue: got acka=%b rdack=%b we=%b re=%b required 1 1 1 1", ack_a, rd_ack, ram_we, ram_re);
    end
    tick();
    idle_inputs();
    vectors++;
    if (rd_valid !== 1'b1 || rd_data !== 32'h12345678) begin
      miscompares++;
      $display("FAIL bypass_data: got valid=%b data=%h required 1 12345678", rd_valid, rd_data);
    end
  endtask

  task automatic test_flush();
    flush = 1'b1; wr_req_a = 1'b1; wr_addr_a = 3'd7; wr_data_a = 32'h77777777;
    #1;
    vectors++;
    if (ack_a !== 1'b1 || ram_we !== 1'b1 || ram_waddr !== 3'd7 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_write: got acka=%b we=%b waddr=%0d busy=%b required 1 1 7 0", ack_a, ram_we, ram_waddr, busy);
    end
    tick();
    idle_inputs();
    repeat (4) tick();
    flush = 1'b1;
    #1;
    vectors++;
    if (busy !== 1'b1 || ram_waddr !== 3'd4) begin
      miscompares++;
      $display("FAIL flush_at4: got busy=%b waddr=%0d required 1 4", busy, ram_waddr);
    end
    tick();
    flush = 1'b0;
    check_sweep("flush_sweep");
    do_read("flush_read2", 3'd2, 32'h0);
    do_read("flush_read7", 3'd7, 32'h0);
    do_read("flush_read3", 3'd3, 32'h0);
  endtask

  task automatic test_reset_mid_sweep();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (6) tick();
    #1;
    vectors++;
    if (busy !== 1'b1 || ram_waddr !== 3'd6) begin
      miscompares++;
      $display("FAIL pre_reset: got busy=%b waddr=%0d required 1 6", busy, ram_waddr);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b0 || ram_we !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset: got busy=%b we=%b required 0 0", busy, ram_we);
    end
    tick();
    rst_n = 1'b1;
    check_sweep("resweep");
  endtask

  initial begin
    flush = 1'b0; rst_n = 1'b0;
    wr_req_a = 1'b0; wr_req_b = 1'b0; rd_req = 1'b0;
    wr_addr_a = '0; wr_addr_b = '0; rd_addr = '0;
    wr_data_a = '0; wr_data_b = '0;
    test_reset();
    test_sweep_after_reset();
    test_single_write();
    test_arbitration();
    test_back_to_back_bypass();
    test_flush();
    test_reset_mid_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
